// File: rtl/phasegen_n.sv
// rtl/phasegen_n.sv - parametrised one-hot instruction-phase generator with run/step/drain/halt control
module phasegen_n #(
  parameter int NPHASE = 4,
  parameter int CNTW   = 16,
  localparam int IDXW  = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              step_phase,
  input  logic              step_inst,
  input  logic [CNTW-1:0]   step_n,
  input  logic              stall,
  input  logic              halt_req,
  output logic [NPHASE-1:0] cstate,
  output logic [IDXW-1:0]   phase_idx,
  output logic              running,
  output logic              halted,
  output logic              inst_done,
  output logic [CNTW-1:0]   inst_count
);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_RUN,
    ST_STEP_INST,
    ST_STEP_PHASE,
    ST_DRAIN
  } state_t;

  localparam logic [NPHASE-1:0] PHASE0 = NPHASE'(1);

  state_t            state_q, state_d;
  logic [NPHASE-1:0] cstate_q, cstate_d;
  logic [CNTW-1:0]   rem_q, rem_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;

  logic              one_hot;
  logic              adv;
  logic              wrap;

  // Phase advance qualifiers: a wrap is an advance out of the last phase
  always_comb begin
    one_hot = (cstate_q != '0) && ((cstate_q & (cstate_q - PHASE0)) == '0);
    adv     = (state_q != ST_STOP) && !stall;
    wrap    = adv && one_hot && cstate_q[NPHASE-1];
  end

  // Phase rotation, with recovery to phase 0 from any corrupted vector
  always_comb begin
    cstate_d = cstate_q;
    if (!one_hot) begin
      cstate_d = PHASE0;
    end else if (adv) begin
      cstate_d = {cstate_q[NPHASE-2:0], cstate_q[NPHASE-1]};
    end
  end

  // Instruction counter and completion pulse, both driven by wrap
  always_comb begin
    count_d = count_q;
    done_d  = wrap;
    if (wrap) begin
      count_d = count_q + CNTW'(1);
    end
  end

  // Control FSM: command acceptance in STOP, graceful stop, halt at instruction boundary
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    halted_d = halted_q;
    unique case (state_q)
      ST_STOP: begin
        if (step_phase) begin
          state_d  = ST_STEP_PHASE;
          halted_d = 1'b0;
        end else if (step_inst) begin
          state_d  = ST_STEP_INST;
          rem_d    = (step_n == '0) ? CNTW'(1) : step_n;
          halted_d = 1'b0;
        end else if (run) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (wrap && halt_req) begin
          state_d  = ST_STOP;
          halted_d = 1'b1;
        end else if (run) begin
          state_d = wrap ? ST_STOP : ST_DRAIN;
        end
      end
      ST_STEP_INST: begin
        if (wrap) begin
          rem_d = rem_q - CNTW'(1);
          if (halt_req) begin
            state_d  = ST_STOP;
            halted_d = 1'b1;
          end else if (rem_q == CNTW'(1)) begin
            state_d = ST_STOP;
          end else if (run) begin
            state_d = ST_DRAIN;
          end
        end else if (run) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wrap) begin
          state_d = ST_STOP;
          if (halt_req) begin
            halted_d = 1'b1;
          end
        end
      end
      ST_STEP_PHASE: begin
        // The single advance happens through adv in the same cycle
        if (!stall) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_STOP;
      cstate_q <= PHASE0;
      rem_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cstate_q <= cstate_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  // Binary index of the active phase
  always_comb begin
    phase_idx = '0;
    for (int i = 0; i < NPHASE; i++) begin
      if (cstate_q[i]) begin
        phase_idx = IDXW'(i);
      end
    end
  end

  assign cstate     = cstate_q;
  assign running    = (state_q != ST_STOP);
  assign halted     = halted_q;
  assign inst_done  = done_q;
  assign inst_count = count_q;

endmodule
